csa_final_adder: RTL and testbench
==================================

Name: csa_final_adder

Overview:
- Carry-propagate stage directly downstream of the signed 4x4 partial-product/compression block `mult`.
- Consumes its two carry-save rows (result1, result2) and produces the binary product as their sum mod 2^WIDTH.
- The addition is split into CHUNK-bit slices, one pipeline stage per slice, so the carry ripple per cycle is bounded.
- Elastic valid/ready handshakes on both sides allow back-to-back operation and backpressure without data loss.

Parameters:
- WIDTH, 8, operand/result width; equals 2x multiplier operand width.
- CHUNK, 4, bits summed per pipeline stage; WIDTH must be an integer multiple of CHUNK (elaboration error otherwise).
- STAGES, WIDTH/CHUNK, derived; number of pipeline stages and nominal latency.

Ports:
- clk, input, 1, single clock; all state updates on rising edge.
- rst, input, 1, synchronous active-high reset.
- in_valid, input, 1, in_row1/in_row2 carry a valid pair.
- in_ready, output, 1, block accepts the pair this cycle.
- in_row1, input, WIDTH, first carry-save row (result1 of mult).
- in_row2, input, WIDTH, second carry-save row (result2 of mult).
- out_valid, output, 1, out_sum/out_cout valid.
- out_ready, input, 1, consumer accepts the result this cycle.
- out_sum, output, WIDTH, (in_row1 + in_row2) mod 2^WIDTH; the signed product in two's complement.
- out_cout, output, 1, carry out of bit WIDTH-1; informational only (expected with Baugh-Wooley constant-1 terms, not an error).

Behaviour:
- Clock and reset:
  - One clock domain.
  - Reset is synchronous and active-high: while rst=1 at a rising edge, all stage valid flags clear.
  - After reset: out_valid=0, out_sum=0, out_cout=0, in_ready=1 (from the first cycle after rst deasserts).
  - Data registers are also cleared to 0 on reset.
- Transfer rules:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
- Stage k (0..STAGES-1) holds:
  - valid flag v[k].
  - Accumulated low sum bits [CHUNK*(k+1)-1:0].
  - Carry into slice k+1.
  - Untouched upper operand bits of both rows.
- Stage 0 loads: slice 0 = row1[CHUNK-1:0] + row2[CHUNK-1:0] (carry-in 0); carry and upper bits are captured.
- Stage k>0 loads from stage k-1: slice k = row1 slice + row2 slice + carry from k-1; lower sum bits are passed through.
- Last stage drives the outputs:
  - out_sum = full accumulated sum.
  - out_cout = final slice carry.
  - out_valid = v[STAGES-1].
- Advance rule, evaluated from the last stage backward:
  - adv[STAGES-1] = !v[STAGES-1] || out_ready.
  - adv[k] = !v[k] || adv[k+1].
  - in_ready = adv[0]. This is combinational from out_ready; no registered-ready skid is required.
- Stage update when adv[k] = 1:
  - Stage k loads from its predecessor (or from the input for k=0).
  - Its valid flag takes the predecessor's valid (in_valid && in_ready for k=0).
- Stage hold when adv[k] = 0: stage k holds data and valid unchanged.
- Latency and throughput:
  - Latency is exactly STAGES cycles from input transfer to out_valid, with no backpressure.
  - Throughput is 1 result/cycle sustained.
- Capacity and ordering:
  - Capacity is STAGES results.
  - Results leave in input order; none dropped or duplicated.
- Full pipeline with out_ready=0: in_ready=0; all registers hold.
- Full pipeline with simultaneous out_ready=1 and in_valid=1: output and input transfers occur in the same cycle; the pipeline stays full.
- Empty pipeline: out_valid=0. out_sum/out_cout hold their last value and are don't-care for checking.
- Wrap-around: the sum is modulo 2^WIDTH with no saturation; the carry beyond bit WIDTH-1 appears only on out_cout.
- Reset mid-operation: in-flight results are discarded with no output transfer. out_valid=0 the cycle after the reset edge.
- in_valid is ignored in any cycle where rst=1.
- Input stability: upstream may change rows freely when in_valid=0. When in_valid=1 and in_ready=0, upstream must hold the rows; the block is not required to check this.

Test Plan:
- Reset, then a single pair row1=8'h0F, row2=8'h01 with out_ready=1 -> out_valid rises exactly 2 cycles after acceptance; out_sum=8'h10, out_cout=0. Checks the inter-slice carry.
- Pair row1=8'hF0, row2=8'h50 -> out_sum=8'h40, out_cout=1. Checks wrap-around, e.g. (-8)*(-8)=64 after constant-1 compensation.
- 16 back-to-back random pairs with in_valid=1 and out_ready=1 -> in_ready stays 1; 16 results in order, each equal to (r1+r2) mod 256, one per cycle after a 2-cycle fill.
- Hold out_ready=0 while offering 3 pairs (8'h01+8'h01, 8'h02+8'h02, 8'h03+8'h03) -> in_ready drops to 0 after 2 acceptances and the third is held. After out_ready=1, outputs are 8'h02, 8'h04, 8'h06 in order with no loss.
- Pipeline full, out_ready=1 and in_valid=1 in the same cycle -> one output transfer and one input transfer in that cycle; occupancy stays at 2.
- Assert rst for 1 cycle with 2 results in flight -> out_valid=0 the next cycle and in_ready=1; no stale result is ever presented afterwards.
- Sweep all 256x256 exhaustive pairs with random out_ready toggling -> every result matches the reference sum; scoreboard count equals input count.

Source files
------------

// File: rtl/csa_final_adder.sv
// csa_final_adder: carry-propagate adder for the two carry-save rows of mult.
// The sum is built CHUNK bits per pipeline stage, so each stage ripples a
// carry across at most CHUNK bits. Elastic valid/ready is used on both sides,
// and ready propagates combinationally backward from out_ready.
module csa_final_adder #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_row1,
   input  logic [WIDTH-1:0] in_row2,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout
);

   localparam int unsigned STAGES = WIDTH / CHUNK;

   if (CHUNK == 0 || (WIDTH % CHUNK) != 0) begin : g_bad_chunk
      $error("csa_final_adder: WIDTH must be a non-zero multiple of CHUNK");
   end

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      logic             v_q;
      logic             carry_q;
      logic [WIDTH-1:0] sum_q;
      logic             adv;
      logic             adv_next;
      logic             v_in;
      logic             cin;
      logic [WIDTH-1:0] row1_in;
      logic [WIDTH-1:0] row2_in;
      logic [WIDTH-1:0] sum_in;
      logic [WIDTH-1:0] sum_nxt;
      logic [CHUNK:0]   slice;

      // Stage 0 is fed by the input port; later stages read their predecessor.
      if (k == 0) begin : g_src
         always_comb begin
            row1_in = in_row1;
            row2_in = in_row2;
            sum_in  = '0;
            cin     = 1'b0;
            v_in    = in_valid && adv;
         end
      end else begin : g_src
         always_comb begin
            row1_in = g_stage[k-1].g_rows.row1_q;
            row2_in = g_stage[k-1].g_rows.row2_q;
            sum_in  = g_stage[k-1].sum_q;
            cin     = g_stage[k-1].carry_q;
            v_in    = g_stage[k-1].v_q;
         end
      end

      // The last stage may advance when the consumer takes its result.
      if (k == STAGES - 1) begin : g_adv
         always_comb adv_next = out_ready;
      end else begin : g_adv
         always_comb adv_next = g_stage[k+1].adv;
      end

      // Add this stage's slice and splice it into the running sum.
      always_comb begin
         adv     = !v_q || adv_next;
         slice   = {1'b0, row1_in[k*CHUNK +: CHUNK]}
                 + {1'b0, row2_in[k*CHUNK +: CHUNK]}
                 + {{CHUNK{1'b0}}, cin};
         sum_nxt = sum_in;
         sum_nxt[k*CHUNK +: CHUNK] = slice[CHUNK-1:0];
      end

      // Valid follows the predecessor on advance; data loads only with a valid item.
      always_ff @(posedge clk) begin
         if (rst) begin
            v_q     <= 1'b0;
            sum_q   <= '0;
            carry_q <= 1'b0;
         end else if (adv) begin
            v_q <= v_in;
            if (v_in) begin
               sum_q   <= sum_nxt;
               carry_q <= slice[CHUNK];
            end
         end
      end

      // Operand rows are only carried forward to stages that still need them.
      if (k < STAGES - 1) begin : g_rows
         logic [WIDTH-1:0] row1_q;
         logic [WIDTH-1:0] row2_q;

         // Capture both rows alongside the partial sum.
         always_ff @(posedge clk) begin
            if (rst) begin
               row1_q <= '0;
               row2_q <= '0;
            end else if (adv && v_in) begin
               row1_q <= row1_in;
               row2_q <= row2_in;
            end
         end
      end
   end

   // Outputs come straight from the last stage; input readiness from the first.
   always_comb begin
      in_ready  = g_stage[0].adv;
      out_valid = g_stage[STAGES-1].v_q;
      out_sum   = g_stage[STAGES-1].sum_q;
      out_cout  = g_stage[STAGES-1].carry_q;
   end

endmodule

// File: tb/tb_csa_final_adder.sv
// Testbench for csa_final_adder (WIDTH=8, CHUNK=4): directed scenarios plus
// random and exhaustive traffic against a queue-based reference of (r1 + r2).
module tb_csa_final_adder;

   localparam int unsigned W = 8;

   logic         clk       = 1'b0;
   logic         rst       = 1'b1;
   logic         in_valid  = 1'b0;
   logic         out_ready = 1'b0;
   logic [W-1:0] in_row1   = '0;
   logic [W-1:0] in_row2   = '0;
   logic         in_ready;
   logic         out_valid;
   logic [W-1:0] out_sum;
   logic         out_cout;

   int checks    = 0;
   int failures  = 0;
   int in_count  = 0;
   int out_count = 0;

   logic [W:0] ref_q[$];
   logic [W:0] exp_v;

   csa_final_adder #(.WIDTH(8), .CHUNK(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_row1   (in_row1),
      .in_row2   (in_row2),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_cout  (out_cout)
   );

   always #5 clk = ~clk;

   // Scoreboard: inputs are driven just after posedge, so negedge sees the
   // values that the next rising edge will act on.
   always @(negedge clk) begin
      if (rst) begin
         ref_q.delete();
      end else begin
         if (out_valid && out_ready) begin
            checks++;
            out_count++;
            if (ref_q.size() == 0) begin
               failures++;
               $display("FAIL sb_unexpected: got sum=%h cout=%b with no result pending", out_sum, out_cout);
            end else begin
               exp_v = ref_q.pop_front();
               if ({out_cout, out_sum} !== exp_v) begin
                  failures++;
                  $display("FAIL sb_result: got cout=%b sum=%h, expected cout=%b sum=%h", out_cout, out_sum, exp_v[W], exp_v[W-1:0]);
               end
            end
         end
         if (in_valid && in_ready) begin
            ref_q.push_back({1'b0, in_row1} + {1'b0, in_row2});
            in_count++;
         end
      end
   end

   // Present a pair until accepted (bounded); returns at posedge+1 with in_valid low.
   task automatic offer(input logic [W-1:0] a, input logic [W-1:0] b, output bit ok);
      in_row1  = a;
      in_row2  = b;
      in_valid = 1'b1;
      ok = 1'b0;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (in_ready) begin
            ok = 1'b1;
            break;
         end
         @(posedge clk); #1;
      end
      if (ok) begin
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      out_ready = 1'b1;
      in_valid  = 1'b0;
      n = 0;
      while (ref_q.size() != 0 && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      checks++;
      if (ref_q.size() != 0) begin
         failures++;
         $display("FAIL drain_timeout: %0d results pending, expected 0", ref_q.size());
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b, expected 0", out_valid); end
      checks++; if (out_sum !== 8'h00) begin failures++; $display("FAIL reset_out_sum: got %h, expected 00", out_sum); end
      checks++; if (out_cout !== 1'b0) begin failures++; $display("FAIL reset_out_cout: got %b, expected 0", out_cout); end
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b, expected 1", in_ready); end
      @(posedge clk); #1;
   endtask

   task automatic test_single(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic [W-1:0] exp_sum, input logic exp_cout);
      bit ok;
      int n;
      out_ready = 1'b1;
      offer(a, b, ok);
      checks++; if (!ok) begin failures++; $display("FAIL %s_accept: got not accepted, expected accepted", name); end
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!out_valid && n < 10);
      checks++; if (n != 2) begin failures++; $display("FAIL %s_latency: got %0d cycles, expected 2", name, n); end
      checks++; if (out_sum !== exp_sum) begin failures++; $display("FAIL %s_sum: got %h, expected %h", name, out_sum, exp_sum); end
      checks++; if (out_cout !== exp_cout) begin failures++; $display("FAIL %s_cout: got %b, expected %b", name, out_cout, exp_cout); end
      @(posedge clk); #1;
      drain();
   endtask

   task automatic test_back_to_back();
      int base;
      base = out_count;
      out_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         in_row1  = W'($urandom());
         in_row2  = W'($urandom());
         in_valid = 1'b1;
         @(negedge clk);
         checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_in_ready[%0d]: got %b, expected 1", i, in_ready); end
         if (i >= 2) begin
            checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL b2b_out_valid[%0d]: got %b, expected 1", i, out_valid); end
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      drain();
      checks++; if (out_count - base != 16) begin failures++; $display("FAIL b2b_count: got %0d results, expected 16", out_count - base); end
   endtask

   task automatic test_backpressure();
      int base;
      base = out_count;
      out_ready = 1'b0;
      in_row1 = 8'h01; in_row2 = 8'h01; in_valid = 1'b1;
      @(negedge clk);
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_accept1: got in_ready=%b, expected 1", in_ready); end
      @(posedge clk); #1;
      in_row1 = 8'h02; in_row2 = 8'h02;
      @(negedge clk);
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_accept2: got in_ready=%b, expected 1", in_ready); end
      @(posedge clk); #1;
      in_row1 = 8'h03; in_row2 = 8'h03;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_full_in_ready[%0d]: got %b, expected 0", i, in_ready); end
         checks++; if (out_valid !== 1'b1 || out_sum !== 8'h02) begin failures++; $display("FAIL bp_hold_out[%0d]: got valid=%b sum=%h, expected valid=1 sum=02", i, out_valid, out_sum); end
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      @(negedge clk);
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_release: got in_ready=%b, expected 1", in_ready); end
      @(posedge clk); #1;
      in_valid = 1'b0;
      drain();
      checks++; if (out_count - base != 3) begin failures++; $display("FAIL bp_count: got %0d results, expected 3", out_count - base); end
   endtask

   task automatic test_full_simul();
      bit ok;
      out_ready = 1'b0;
      offer(8'h11, 8'h22, ok);
      offer(8'h33, 8'h44, ok);
      in_row1 = 8'h55; in_row2 = 8'h66; in_valid = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      checks++; if (in_ready !== 1'b1 || out_valid !== 1'b1) begin failures++; $display("FAIL sim_both: got in_ready=%b out_valid=%b, expected 1 1", in_ready, out_valid); end
      @(posedge clk); #1;
      in_valid = 1'b0;
      out_ready = 1'b0;
      @(negedge clk);
      checks++; if (ref_q.size() != 2) begin failures++; $display("FAIL sim_occupancy: got %0d, expected 2", ref_q.size()); end
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL sim_full: got in_ready=%b, expected 0", in_ready); end
      checks++; if (out_valid !== 1'b1 || out_sum !== 8'h77) begin failures++; $display("FAIL sim_head: got valid=%b sum=%h, expected valid=1 sum=77", out_valid, out_sum); end
      @(posedge clk); #1;
      drain();
   endtask

   task automatic test_reset_mid();
      bit ok;
      int stale;
      out_ready = 1'b0;
      offer(W'($urandom()), W'($urandom()), ok);
      offer(W'($urandom()), W'($urandom()), ok);
      rst = 1'b1;
      in_valid = 1'b1;
      in_row1 = 8'hAA; in_row2 = 8'h55;
      @(posedge clk); #1;
      rst = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rmid_out_valid: got %b, expected 0", out_valid); end
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rmid_in_ready: got %b, expected 1", in_ready); end
      out_ready = 1'b1;
      stale = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (out_valid) stale++;
         @(posedge clk); #1;
      end
      checks++; if (stale != 0) begin failures++; $display("FAIL rmid_stale: got %0d stale outputs, expected 0", stale); end
   endtask

   task automatic test_exhaustive();
      int idx;
      int cyc;
      int base_in;
      int base_out;
      bit acc;
      base_in  = in_count;
      base_out = out_count;
      idx = 0;
      cyc = 0;
      while (idx < 65536 && cyc < 80000) begin
         in_row1   = idx[15:8];
         in_row2   = idx[7:0];
         in_valid  = 1'b1;
         out_ready = ($urandom_range(15) != 0);
         @(negedge clk);
         acc = in_ready;
         @(posedge clk); #1;
         if (acc) idx++;
         cyc++;
      end
      in_valid = 1'b0;
      drain();
      checks++; if (idx != 65536) begin failures++; $display("FAIL exh_all_sent: got %0d pairs, expected 65536", idx); end
      checks++; if (out_count - base_out != in_count - base_in) begin failures++; $display("FAIL exh_count: got %0d outputs, expected %0d", out_count - base_out, in_count - base_in); end
   endtask

   initial begin
      test_reset();
      test_single("carry", 8'h0F, 8'h01, 8'h10, 1'b0);
      test_single("wrap", 8'hF0, 8'h50, 8'h40, 1'b1);
      test_back_to_back();
      test_backpressure();
      test_full_simul();
      test_reset_mid();
      test_exhaustive();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
